// File: rtl/dequant_izigzag_seq_if.sv
// rtl/dequant_izigzag_seq_if.sv - coefficient-in / table-write / coefficient-out bundle
interface dequant_izigzag_seq_if #(
  parameter int COEFF_W = 12,
  parameter int Q_W     = 8,
  parameter int OUT_W   = 16
);
  logic signed [COEFF_W-1:0] coeff_in;
  logic                      coeff_valid;
  logic                      coeff_last;
  logic                      coeff_ready;
  logic                      qtab_wr_en;
  logic [5:0]                qtab_addr;
  logic [Q_W-1:0]            qtab_data;
  logic signed [OUT_W-1:0]   coef_out;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;
  logic                      err_sync;

  modport master (
    output coeff_in, coeff_valid, coeff_last, qtab_wr_en, qtab_addr, qtab_data, out_ready,
    input  coeff_ready, coef_out, out_valid, out_last, err_sync
  );

  modport slave (
    input  coeff_in, coeff_valid, coeff_last, qtab_wr_en, qtab_addr, qtab_data, out_ready,
    output coeff_ready, coef_out, out_valid, out_last, err_sync
  );
endinterface

// File: rtl/dequant_izigzag_seq.sv
// rtl/dequant_izigzag_seq.sv - dequantize zigzag coefficients into a ping-pong raster buffer
module dequant_izigzag_seq #(
  parameter int COEFF_W = 12,
  parameter int Q_W     = 8,
  parameter int OUT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dequant_izigzag_seq_if.slave bus
);
  localparam int PW = COEFF_W + Q_W + 1;
  localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [Q_W-1:0]          r_qtab [64];
  logic signed [OUT_W-1:0] r_mem  [128];
  bank_st_t                r_st   [2];
  logic [5:0]              r_wr_cnt;
  logic [5:0]              r_rd_cnt;
  logic                    r_wr_sel;
  logic                    r_rd_sel;
  logic                    r_en;
  logic                    r_err;
  logic signed [OUT_W-1:0] r_out;
  logic                    r_oval;
  logic                    r_olast;

  logic                    w_wr_open;
  logic                    w_acc;
  logic                    w_close;
  logic [5:0]              w_raster;
  logic signed [PW-1:0]    w_coef_x;
  logic signed [PW-1:0]    w_q_x;
  logic signed [PW-1:0]    w_prod;
  logic signed [OUT_W-1:0] w_sat;
  logic                    w_hs;
  logic                    w_hs_last;
  logic                    w_can;
  logic                    w_src;
  bank_st_t                w_src_st;
  logic                    w_src_full;
  logic                    w_load;

  assign w_wr_open = (r_st[r_wr_sel] == EMPTY) || (r_st[r_wr_sel] == FILLING);
  assign w_acc     = bus.coeff_valid && r_en && w_wr_open;
  assign w_close   = w_acc && (r_wr_cnt == 6'd63);
  assign w_raster  = ZZ[r_wr_cnt];

  assign w_coef_x = {{(Q_W + 1){bus.coeff_in[COEFF_W-1]}}, bus.coeff_in};
  assign w_q_x    = {{(COEFF_W + 1){1'b0}}, r_qtab[w_raster]};
  assign w_prod   = w_coef_x * w_q_x;
  assign w_sat    = (w_prod > SAT_HI) ? SAT_HI[OUT_W-1:0] :
                    (w_prod < SAT_LO) ? SAT_LO[OUT_W-1:0] : w_prod[OUT_W-1:0];

  // A bank closing this very cycle counts as full, so word 0 leaves one cycle after the 64th accept.
  assign w_hs       = r_oval && bus.out_ready;
  assign w_hs_last  = w_hs && r_olast;
  assign w_can      = !r_oval || bus.out_ready;
  assign w_src      = w_hs_last ? ~r_rd_sel : r_rd_sel;
  assign w_src_st   = r_st[w_src];
  assign w_src_full = (w_src_st == FULL) ||
                      ((w_src_st == FILLING) && w_close && (r_wr_sel == w_src));
  assign w_load     = w_can && (w_src_full || ((w_src_st == DRAINING) && (r_rd_cnt != 6'd0)));

  assign bus.coeff_ready = r_en && w_wr_open;
  assign bus.coef_out    = r_out;
  assign bus.out_valid   = r_oval;
  assign bus.out_last    = r_olast;
  assign bus.err_sync    = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) r_qtab[i] <= Q_W'(1);
    end else if (bus.qtab_wr_en) begin
      r_qtab[bus.qtab_addr] <= bus.qtab_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_mem[{r_wr_sel, w_raster}] <= w_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) r_st[b] <= EMPTY;
      r_wr_cnt <= 6'd0;
      r_rd_cnt <= 6'd0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_en     <= 1'b0;
      r_err    <= 1'b0;
      r_out    <= '0;
      r_oval   <= 1'b0;
      r_olast  <= 1'b0;
    end else begin
      r_en <= 1'b1;
      if (w_acc) begin
        r_wr_cnt <= r_wr_cnt + 6'd1;
        if (bus.coeff_last != (r_wr_cnt == 6'd63)) r_err <= 1'b1;
        if (w_close) begin
          r_st[r_wr_sel] <= FULL;
          r_wr_sel       <= ~r_wr_sel;
        end else begin
          r_st[r_wr_sel] <= FILLING;
        end
      end
      if (w_hs_last) begin
        r_st[r_rd_sel] <= EMPTY;
        r_rd_sel       <= ~r_rd_sel;
      end
      // Placed after the writer so a same-cycle close-and-load leaves the bank DRAINING.
      if (w_load) begin
        r_out    <= r_mem[{w_src, r_rd_cnt}];
        r_oval   <= 1'b1;
        r_olast  <= (r_rd_cnt == 6'd63);
        r_rd_cnt <= r_rd_cnt + 6'd1;
        if (r_rd_cnt == 6'd0) r_st[w_src] <= DRAINING;
      end else if (w_hs) begin
        r_oval  <= 1'b0;
        r_olast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dequant_izigzag_seq.sv
// tb/tb_dequant_izigzag_seq.sv - randomized bench for dequant_izigzag_seq against a block-level model
module tb_dequant_izigzag_seq;
  localparam int COEFF_W = 12;
  localparam int Q_W     = 8;
  localparam int OUT_W   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dequant_izigzag_seq_if #(.COEFF_W(COEFF_W), .Q_W(Q_W), .OUT_W(OUT_W)) bus ();
  dequant_izigzag_seq #(.COEFF_W(COEFF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int zz_m [64];
  int q_model [64];
  int blk [64];
  int exp_q [$];
  int got_d [$];
  bit got_l [$];
  int got_c [$];
  int last_acc_cyc;
  int stall_seen = 0;
  int stall_viol = 0;
  bit prev_hold = 1'b0;
  int prev_d;
  bit prev_l;

  always @(posedge clk) cyc <= cyc + 1;

  // Observes handshakes between edges; inputs change only at posedge+1.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        stall_seen++;
        if (bus.out_valid !== 1'b1 || int'(bus.coef_out) != prev_d || bus.out_last !== prev_l)
          stall_viol++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_d = int'(bus.coef_out);
      prev_l = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        got_d.push_back(int'(bus.coef_out));
        got_l.push_back(bus.out_last);
        got_c.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic push_expected();
    int e [64];
    longint p;
    for (int k = 0; k < 64; k++) begin
      p = longint'(blk[k]) * longint'(q_model[zz_m[k]]);
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      e[zz_m[k]] = int'(p);
    end
    for (int r = 0; r < 64; r++) exp_q.push_back(e[r]);
  endtask

  task automatic send_coeff(input int v, input bit last);
    int n = 0;
    bus.coeff_in = COEFF_W'(v);
    bus.coeff_valid = 1'b1;
    bus.coeff_last = last;
    while (!bus.coeff_ready && n < 3000) begin
      tick();
      n++;
    end
    if (!bus.coeff_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout coeff_ready stuck at %b, required 1", bus.coeff_ready);
    end
    tick();
    last_acc_cyc = cyc;
    bus.coeff_valid = 1'b0;
    bus.coeff_last = 1'b0;
  endtask

  task automatic send_block(input int last_k);
    for (int k = 0; k < 64; k++) send_coeff(blk[k], k == last_k);
  endtask

  task automatic qwrite(input int a, input int d);
    bus.qtab_wr_en = 1'b1;
    bus.qtab_addr = 6'(a);
    bus.qtab_data = Q_W'(d);
    tick();
    bus.qtab_wr_en = 1'b0;
    q_model[a] = d;
  endtask

  task automatic wait_words(input int n, output bit ok);
    int t = 0;
    while (got_d.size() < n && t < 5000) begin
      tick();
      t++;
    end
    ok = (got_d.size() >= n);
  endtask

  task automatic rand_block();
    for (int k = 0; k < 64; k++) blk[k] = int'($urandom_range(0, 4095)) - 2048;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.coef_out !== '0 || bus.err_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs valid=%b last=%b data=%0d err=%b, required 0 0 0 0",
               bus.out_valid, bus.out_last, bus.coef_out, bus.err_sync);
    end
    rst_n = 1'b1;
    checks++;
    if (bus.coeff_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_first coeff_ready=%b, required 0", bus.coeff_ready);
    end
    tick();
    checks++;
    if (bus.coeff_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after coeff_ready=%b, required 1", bus.coeff_ready);
    end
  endtask

  task automatic test_identity();
    bit ok;
    clear_q();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 64; k++) blk[k] = k;
    push_expected();
    send_block(63);
    wait_words(64, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL identity_count got %0d words, required 64", got_d.size());
    end else begin
      checks++;
      if (got_c[0] != last_acc_cyc) begin
        errors++;
        $display("FAIL identity_latency first word cycle %0d, required %0d", got_c[0], last_acc_cyc);
      end
      checks++;
      if (got_d[2] != 5 || got_d[8] != 2 || got_d[63] != 63) begin
        errors++;
        $display("FAIL identity_spot r2=%0d r8=%0d r63=%0d, required 5 2 63", got_d[2], got_d[8], got_d[63]);
      end
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got_d[i] != exp_q[i] || got_l[i] != (i == 63)) begin
          errors++;
          $display("FAIL identity_word[%0d] got %0d last %b, required %0d last %b",
                   i, got_d[i], got_l[i], exp_q[i], i == 63);
        end
      end
    end
  endtask

  task automatic test_scaling();
    bit ok;
    clear_q();
    for (int a = 0; a < 64; a++) qwrite(a, (a == 0) ? 16 : (a == 1) ? 255 : 2);
    for (int k = 0; k < 64; k++) blk[k] = 0;
    blk[0] = 100; blk[1] = 200; blk[2] = -3;
    push_expected();
    send_block(63);
    wait_words(64, ok);
    checks++;
    if (!ok || got_d[0] != 1600 || got_d[1] != 32767 || got_d[8] != -6) begin
      errors++;
      $display("FAIL scaling_pos got %0d words r0=%0d r1=%0d r8=%0d, required 1600 32767 -6",
               got_d.size(), ok ? got_d[0] : 0, ok ? got_d[1] : 0, ok ? got_d[8] : 0);
    end
    clear_q();
    blk[1] = -200;
    push_expected();
    checks++;
    if (bus.coeff_ready !== 1'b1) begin
      errors++;
      $display("FAIL scaling_ready coeff_ready=%b, required 1", bus.coeff_ready);
    end
    bus.qtab_wr_en = 1'b1;
    bus.qtab_addr = 6'd0;
    bus.qtab_data = Q_W'(3);
    send_coeff(blk[0], 1'b0);
    bus.qtab_wr_en = 1'b0;
    q_model[0] = 3;
    for (int k = 1; k < 64; k++) send_coeff(blk[k], k == 63);
    wait_words(64, ok);
    checks++;
    if (!ok || got_d[0] != 1600 || got_d[1] != -32768 || got_d[8] != -6) begin
      errors++;
      $display("FAIL scaling_neg got %0d words r0=%0d r1=%0d r8=%0d, required 1600 -32768 -6",
               got_d.size(), ok ? got_d[0] : 0, ok ? got_d[1] : 0, ok ? got_d[8] : 0);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    clear_q();
    for (int a = 0; a < 64; a++) qwrite(a, int'($urandom_range(0, 255)));
    bus.out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rand_block();
      push_expected();
      send_block(63);
    end
    repeat (4) tick();
    checks++;
    if (bus.coeff_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready after 128 accepts coeff_ready=%b, required 0", bus.coeff_ready);
    end
    fork
      begin
        rand_block();
        push_expected();
        send_block(63);
      end
      begin
        repeat (20) tick();
        bus.out_ready = 1'b1;
      end
    join
    wait_words(192, ok);
    repeat (30) tick();
    checks++;
    if (got_d.size() != 192) begin
      errors++;
      $display("FAIL bp_count got %0d words, required 192", got_d.size());
    end else begin
      for (int i = 0; i < 192; i++) begin
        checks++;
        if (got_d[i] != exp_q[i] || got_l[i] != (i % 64 == 63)) begin
          errors++;
          $display("FAIL bp_word[%0d] got %0d last %b, required %0d last %b",
                   i, got_d[i], got_l[i], exp_q[i], i % 64 == 63);
        end
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit stop = 1'b0;
    clear_q();
    stall_seen = 0;
    stall_viol = 0;
    bus.out_ready = 1'b1;
    fork
      begin
        while (!stop) begin
          tick();
          bus.out_ready = ~bus.out_ready;
        end
      end
      begin
        for (int b = 0; b < 2; b++) begin
          rand_block();
          push_expected();
          send_block(63);
        end
        wait_words(128, ok);
        stop = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (stall_viol != 0 || stall_seen == 0) begin
      errors++;
      $display("FAIL stall_hold violations %0d over %0d stalls, required 0 over >0", stall_viol, stall_seen);
    end
    checks++;
    if (got_d.size() != 128) begin
      errors++;
      $display("FAIL stall_count got %0d words, required 128", got_d.size());
    end else begin
      for (int i = 0; i < 128; i++) begin
        checks++;
        if (got_d[i] != exp_q[i] || got_l[i] != (i % 64 == 63)) begin
          errors++;
          $display("FAIL stall_word[%0d] got %0d, required %0d", i, got_d[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    clear_q();
    bus.out_ready = 1'b1;
    rand_block();
    push_expected();
    for (int k = 0; k < 64; k++) begin
      send_coeff(blk[k], k == 10);
      if (k == 9) begin
        checks++;
        if (bus.err_sync !== 1'b0) begin
          errors++;
          $display("FAIL misalign_early err_sync=%b, required 0", bus.err_sync);
        end
      end
      if (k == 10) begin
        checks++;
        if (bus.err_sync !== 1'b1) begin
          errors++;
          $display("FAIL misalign_set err_sync=%b, required 1", bus.err_sync);
        end
      end
    end
    wait_words(64, ok);
    repeat (10) tick();
    checks++;
    if (got_d.size() != 64 || bus.err_sync !== 1'b1) begin
      errors++;
      $display("FAIL misalign_close got %0d words err=%b, required 64 err=1", got_d.size(), bus.err_sync);
    end else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got_d[i] != exp_q[i] || got_l[i] != (i == 63)) begin
          errors++;
          $display("FAIL misalign_word[%0d] got %0d, required %0d", i, got_d[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    for (int a = 0; a < 64; a++) qwrite(a, int'($urandom_range(2, 255)));
    bus.out_ready = 1'b0;
    rand_block();
    send_block(63);
    rand_block();
    for (int k = 0; k < 30; k++) send_coeff(blk[k], 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_sync !== 1'b0 || bus.coeff_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs valid=%b err=%b ready=%b, required 0 0 0",
               bus.out_valid, bus.err_sync, bus.coeff_ready);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int a = 0; a < 64; a++) q_model[a] = 1;
    clear_q();
    bus.out_ready = 1'b1;
    tick();
    rand_block();
    push_expected();
    send_block(63);
    wait_words(64, ok);
    repeat (50) tick();
    checks++;
    if (got_d.size() != 64) begin
      errors++;
      $display("FAIL midreset_count got %0d words, required 64", got_d.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        checks++;
        if (got_d[i] != exp_q[i] || got_l[i] != (i == 63)) begin
          errors++;
          $display("FAIL midreset_word[%0d] got %0d, required %0d", i, got_d[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    int k = 0;
    int lo, hi;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_m[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_m[k] = r * 8 + (s - r); k++; end
      end
    end
    for (int a = 0; a < 64; a++) q_model[a] = 1;
    bus.coeff_in = '0;
    bus.coeff_valid = 1'b0;
    bus.coeff_last = 1'b0;
    bus.qtab_wr_en = 1'b0;
    bus.qtab_addr = '0;
    bus.qtab_data = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_identity();
    test_scaling();
    test_back_pressure();
    test_stall();
    test_misaligned();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout simulation still running, required completion");
    $fatal(1);
  end
endmodule
